axi_stream_initiator: RTL and testbench

- Stream initiator that drives the 10-bit valid/ready write channel of the FIFO–ALU–FIFO pipeline and sinks its 10-bit read channel.
- Generates a programmed burst of operand words (incrementing or LFSR pattern) and limits words in flight with a credit counter.
- Counts returned words, captures the last result, and flags a stalled pipeline with a timeout.
- Serves as the bring-up/traffic source for the ALU pipeline; its ports connect directly to the pipeline's wdata/wvalid/wready and rvalid/rdata/rready.

---
 rtl/axi_alu_pkg.sv | 22 ++
 rtl/stream_pattern_gen.sv | 47 ++++
 rtl/axi_stream_initiator.sv | 189 ++++++++++++++++++
 tb/tb_axi_stream_initiator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_alu_pkg.sv
// axi_alu_pkg: shared width, FSM encoding and LFSR taps for the ALU pipeline stream initiator.
// Rev 1.0
`default_nettype none

package axi_alu_pkg;

    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // x^10 + x^7 + 1 Fibonacci form: feedback = bit9 ^ bit6
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

endpackage

`default_nettype wire

// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen: holds the current burst word; loads a seed and steps by increment or LFSR.
// Rev 1.0
`default_nettype none

module stream_pattern_gen
    import axi_alu_pkg::*;
#(
    parameter int DATA_W = axi_alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_seed,
    input  logic              i_mode,
    input  logic              i_advance,
    output logic [DATA_W-1:0] o_word
);

    logic              r_mode;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_next;

    always_comb begin
        w_next = r_word + DATA_W'(1);
        if (r_mode) begin
            w_next = {r_word[DATA_W-2:0], r_word[LFSR_TAP_HI] ^ r_word[LFSR_TAP_LO]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= 1'b0;
            r_word <= '0;
        end else if (i_load) begin
            r_mode <= i_mode;
            // an all-zero LFSR would lock up, so seed 0 starts at 1
            r_word <= (i_mode && (i_seed == '0)) ? DATA_W'(1) : i_seed;
        end else if (i_advance) begin
            r_word <= w_next;
        end
    end

    assign o_word = r_word;

endmodule

`default_nettype wire

// File: rtl/axi_stream_initiator.sv
// axi_stream_initiator: credit-limited burst source for the ALU pipeline write channel, sink for its read channel.
// Rev 1.0
`default_nettype none

module axi_stream_initiator
    import axi_alu_pkg::*;
#(
    parameter int DATA_W  = axi_alu_pkg::DATA_W,
    parameter int CNT_W   = 8,
    parameter int MAX_OUT = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] seed,
    input  logic              mode,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              rready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  rx_count,
    output logic [DATA_W-1:0] last_rdata
);

    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_sent;
    logic [CNT_W-1:0]   r_rx_count;
    logic [CNT_W-1:0]   r_out;
    logic [IDLE_W-1:0]  r_idle;
    logic               r_timeout_err;
    logic               r_wvalid;
    logic [DATA_W-1:0]  r_last_rdata;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_len_nxt;
    logic [CNT_W-1:0]   w_sent_nxt;
    logic [CNT_W-1:0]   w_rx_nxt;
    logic [CNT_W-1:0]   w_out_nxt;
    logic [CNT_W-1:0]   w_out_upd;
    logic [IDLE_W-1:0]  w_idle_nxt;
    logic               w_err_nxt;
    logic               w_wvalid_nxt;
    logic [DATA_W-1:0]  w_last_nxt;
    logic               w_load;
    logic               w_rready;
    logic               w_whs;
    logic               w_rhs;
    logic               w_tmo;

    assign w_rready = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_whs    = r_wvalid && wready;
    assign w_rhs    = rvalid && w_rready;
    assign w_tmo    = !w_rhs && (r_out != '0) && (r_idle == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        w_out_upd = r_out;
        if (w_whs && !w_rhs) begin
            w_out_upd = r_out + CNT_W'(1);
        end else if (!w_whs && w_rhs && (r_out != '0)) begin
            w_out_upd = r_out - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_sent_nxt   = r_sent;
        w_rx_nxt     = r_rx_count;
        w_out_nxt    = r_out;
        w_idle_nxt   = r_idle;
        w_err_nxt    = r_timeout_err;
        w_wvalid_nxt = r_wvalid;
        w_last_nxt   = r_last_rdata;
        w_load       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_err_nxt = 1'b0;
                    if (len != '0) begin
                        w_state_nxt  = ST_RUN;
                        w_len_nxt    = len;
                        w_sent_nxt   = '0;
                        w_rx_nxt     = '0;
                        w_out_nxt    = '0;
                        w_idle_nxt   = '0;
                        w_load       = 1'b1;
                        w_wvalid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                w_sent_nxt = r_sent + CNT_W'(w_whs);
                w_out_nxt  = w_out_upd;
                if (w_rhs) begin
                    w_rx_nxt   = r_rx_count + CNT_W'(1);
                    w_last_nxt = rdata;
                    w_idle_nxt = '0;
                end else if (r_out != '0) begin
                    w_idle_nxt = r_idle + IDLE_W'(1);
                end

                if (w_tmo) begin
                    w_err_nxt    = 1'b1;
                    w_wvalid_nxt = 1'b0;
                    w_state_nxt  = ST_DONE;
                end else if (r_state == ST_RUN) begin
                    if (w_sent_nxt == r_len) begin
                        w_wvalid_nxt = 1'b0;
                        w_state_nxt  = ST_DRAIN;
                    end else begin
                        // a pending word is held regardless of credit; credit only gates raising
                        w_wvalid_nxt = (r_wvalid && !wready) || (w_out_upd < CNT_W'(MAX_OUT));
                    end
                end else begin
                    w_wvalid_nxt = 1'b0;
                    if (w_rx_nxt >= r_len) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_sent        <= '0;
            r_rx_count    <= '0;
            r_out         <= '0;
            r_idle        <= '0;
            r_timeout_err <= 1'b0;
            r_wvalid      <= 1'b0;
            r_last_rdata  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_sent        <= w_sent_nxt;
            r_rx_count    <= w_rx_nxt;
            r_out         <= w_out_nxt;
            r_idle        <= w_idle_nxt;
            r_timeout_err <= w_err_nxt;
            r_wvalid      <= w_wvalid_nxt;
            r_last_rdata  <= w_last_nxt;
        end
    end

    stream_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_seed    (seed),
        .i_mode    (mode),
        .i_advance (w_whs),
        .o_word    (wdata)
    );

    assign wvalid      = r_wvalid;
    assign rready      = w_rready;
    assign busy        = w_rready;
    assign done        = (r_state == ST_DONE);
    assign timeout_err = r_timeout_err;
    assign rx_count    = r_rx_count;
    assign last_rdata  = r_last_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_initiator.sv
// tb_axi_stream_initiator: directed scenarios against a loopback pipeline model (MAX_OUT=2, TIMEOUT=10).
// Rev 1.0
`default_nettype none

module tb_axi_stream_initiator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic [9:0] seed;
    logic       mode;
    logic       wready;
    logic       rvalid;
    logic [9:0] rdata;
    wire  [9:0] wdata;
    wire        wvalid;
    wire        rready;
    wire        busy;
    wire        done;
    wire        timeout_err;
    wire  [7:0] rx_count;
    wire  [9:0] last_rdata;

    int errors = 0;
    int checks = 0;

    logic [9:0] sent_q[$];
    logic [9:0] rq[$];
    int         done_cnt;
    int         done_edge;
    int         stab_bad;
    int         stall_done;
    int         sent_at_hold;
    logic       wv_at_hold;

    axi_stream_initiator #(
        .DATA_W  (10),
        .CNT_W   (8),
        .MAX_OUT (2),
        .TIMEOUT (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .seed        (seed),
        .mode        (mode),
        .wdata       (wdata),
        .wvalid      (wvalid),
        .wready      (wready),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rready      (rready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .rx_count    (rx_count),
        .last_rdata  (last_rdata)
    );

    always #5 clk = ~clk;

    // Drives one burst; read channel loops written words back with one cycle of latency.
    task automatic run_burst(input logic [9:0] s, input logic [7:0] l, input logic m,
                             input int stall_word, input int stall_cyc, input int rhold,
                             input int max_cyc);
        int         stall_left;
        logic       pv;
        logic       pr;
        logic [9:0] pd;
        logic       whs;
        logic       rhs;
        logic [9:0] wd;
        sent_q.delete();
        rq.delete();
        done_cnt     = 0;
        done_edge    = -1;
        stab_bad     = 0;
        sent_at_hold = -1;
        wv_at_hold   = 1'b0;
        stall_left   = stall_cyc;
        pv = 1'b0; pr = 1'b1; pd = '0;
        seed = s; len = l; mode = m; start = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            if (pv && !pr && (wvalid !== 1'b1 || wdata !== pd)) stab_bad++;
            wready = 1'b1;
            if (wvalid && sent_q.size() == stall_word && stall_left > 0) begin
                wready = 1'b0;
                stall_left--;
            end
            rvalid = (c >= rhold) && (rq.size() > 0);
            rdata  = '0;
            if (rvalid) rdata = rq[0];
            if (c == rhold) begin
                sent_at_hold = sent_q.size();
                wv_at_hold   = wvalid;
            end
            whs = wvalid && wready;
            rhs = rvalid && rready;
            wd  = wdata;
            pv  = wvalid; pr = wready; pd = wdata;
            @(posedge clk); #1;
            start = 1'b0;
            if (rhs) void'(rq.pop_front());
            if (whs) begin
                rq.push_back(wd);
                sent_q.push_back(wd);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) done_edge = c + 1;
            end else if (done_cnt > 0) begin
                break;
            end
        end
        stall_done = stall_cyc - stall_left;
        rvalid = 1'b0;
        wready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; len = '0; seed = '0; mode = 1'b0;
        wready = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", wvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%b exp=0", rready); end
        checks++; if (rx_count !== 8'd0) begin errors++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
        checks++; if (wdata !== 10'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=000", wdata); end
        checks++; if (last_rdata !== 10'd0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_last_err got=%h/%b exp=000/0", last_rdata, timeout_err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_inc_wrap;
        logic [9:0] exp [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        run_burst(10'h3FE, 8'd4, 1'b0, -1, 0, 0, 60);
        checks++; if (sent_q.size() != 4) begin errors++; $display("FAIL inc_count got=%0d exp=4", sent_q.size()); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp[i]) begin errors++; $display("FAIL inc_word%0d got=%h exp=%h", i, sent_q[i], exp[i]); end
        end
        checks++; if (rx_count !== 8'd4) begin errors++; $display("FAIL inc_rx_count got=%0d exp=4", rx_count); end
        checks++; if (last_rdata !== 10'h001) begin errors++; $display("FAIL inc_last_rdata got=%h exp=001", last_rdata); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL inc_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL inc_err_busy got=%b/%b exp=0/0", timeout_err, busy);
        end
    endtask

    task automatic test_lfsr;
        logic [9:0] exp_a [3] = '{10'h001, 10'h002, 10'h004};
        logic [9:0] exp_b [3] = '{10'h200, 10'h001, 10'h002};
        run_burst(10'h000, 8'd3, 1'b1, -1, 0, 0, 60);
        checks++; if (sent_q.size() != 3) begin errors++; $display("FAIL lfsr0_count got=%0d exp=3", sent_q.size()); end
        for (int i = 0; i < 3 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp_a[i]) begin errors++; $display("FAIL lfsr0_word%0d got=%h exp=%h", i, sent_q[i], exp_a[i]); end
        end
        run_burst(10'h200, 8'd3, 1'b1, -1, 0, 0, 60);
        checks++; if (sent_q.size() != 3) begin errors++; $display("FAIL lfsr_fb_count got=%0d exp=3", sent_q.size()); end
        for (int i = 0; i < 3 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp_b[i]) begin errors++; $display("FAIL lfsr_fb_word%0d got=%h exp=%h", i, sent_q[i], exp_b[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [9:0] exp [4] = '{10'h010, 10'h011, 10'h012, 10'h013};
        run_burst(10'h010, 8'd4, 1'b0, 2, 5, 0, 80);
        checks++; if (stall_done != 5) begin errors++; $display("FAIL bp_stall_cycles got=%0d exp=5", stall_done); end
        checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stability got=%0d unstable cycles exp=0", stab_bad); end
        checks++; if (sent_q.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", sent_q.size()); end
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp[i]) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, sent_q[i], exp[i]); end
        end
        checks++; if (rx_count !== 8'd4) begin errors++; $display("FAIL bp_rx_count got=%0d exp=4", rx_count); end
    endtask

    task automatic test_credit;
        run_burst(10'h100, 8'd4, 1'b0, -1, 0, 6, 80);
        checks++; if (sent_at_hold != 2) begin errors++; $display("FAIL credit_sent_before_read got=%0d exp=2", sent_at_hold); end
        checks++; if (wv_at_hold !== 1'b0) begin errors++; $display("FAIL credit_wvalid_blocked got=%b exp=0", wv_at_hold); end
        checks++; if (sent_q.size() != 4) begin errors++; $display("FAIL credit_total got=%0d exp=4", sent_q.size()); end
        checks++; if (rx_count !== 8'd4 || last_rdata !== 10'h103) begin
            errors++; $display("FAIL credit_rx got=%0d/%h exp=4/103", rx_count, last_rdata);
        end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL credit_no_timeout got=%b exp=0", timeout_err); end
    endtask

    task automatic test_timeout;
        run_burst(10'h020, 8'd3, 1'b0, -1, 0, 1000, 60);
        checks++; if (done_edge < 10 || done_edge > 14) begin
            errors++; $display("FAIL tmo_done_time got=%0d cycles exp=10..14", done_edge);
        end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        checks++; if (busy !== 1'b0 || wvalid !== 1'b0) begin
            errors++; $display("FAIL tmo_idle got busy=%b wvalid=%b exp=0/0", busy, wvalid);
        end
        checks++; if (sent_q.size() != 2 || rx_count !== 8'd0) begin
            errors++; $display("FAIL tmo_traffic got sent=%0d rx=%0d exp=2/0", sent_q.size(), rx_count);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL tmo_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_len0;
        run_burst(10'h055, 8'd0, 1'b0, -1, 0, 0, 20);
        checks++; if (done_edge != 1) begin errors++; $display("FAIL len0_done_edge got=%0d exp=1", done_edge); end
        checks++; if (sent_q.size() != 0) begin errors++; $display("FAIL len0_traffic got=%0d exp=0", sent_q.size()); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL len0_err_cleared got=%b exp=0", timeout_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL len0_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid_run;
        seed = 10'h005; len = 8'd8; mode = 1'b0; start = 1'b1;
        wready = 1'b0; rvalid = 1'b1; rdata = 10'h055;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wvalid !== 1'b1 || busy !== 1'b1 || rx_count !== 8'd2) begin
            errors++; $display("FAIL mid_run_state got wvalid=%b busy=%b rx=%0d exp=1/1/2", wvalid, busy, rx_count);
        end
        #2 reset = 1'b0;
        #1;
        checks++; if (wvalid !== 1'b0 || busy !== 1'b0 || rx_count !== 8'd0) begin
            errors++; $display("FAIL async_reset got wvalid=%b busy=%b rx=%0d exp=0/0/0", wvalid, busy, rx_count);
        end
        checks++; if (last_rdata !== 10'd0 || rready !== 1'b0) begin
            errors++; $display("FAIL async_reset_rd got=%h/%b exp=000/0", last_rdata, rready);
        end
        rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_restart;
        logic [9:0] exp [3] = '{10'h0F0, 10'h0F1, 10'h0F2};
        run_burst(10'h0F0, 8'd3, 1'b0, -1, 0, 0, 60);
        checks++; if (sent_q.size() != 3) begin errors++; $display("FAIL restart_count got=%0d exp=3", sent_q.size()); end
        for (int i = 0; i < 3 && i < sent_q.size(); i++) begin
            checks++; if (sent_q[i] !== exp[i]) begin errors++; $display("FAIL restart_word%0d got=%h exp=%h", i, sent_q[i], exp[i]); end
        end
        checks++; if (rx_count !== 8'd3 || done_cnt != 1) begin
            errors++; $display("FAIL restart_done got rx=%0d pulses=%0d exp=3/1", rx_count, done_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_inc_wrap;
        test_lfsr;
        test_backpressure;
        test_credit;
        test_timeout;
        test_len0;
        test_reset_mid_run;
        test_restart;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
